// File: rtl/count_register_writer.sv
// Assembles CPU count-byte writes into the 16-bit (2*DATA_W) 8254 Count Register
// following the RW format of the last control word. Optional BCD digit check: COUNT_BCD_CHECK_EN.
module count_register_writer #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   databus,
  input  logic                write,
  input  logic                ctrl_write,
  input  logic [1:0]          rw_mode,
`ifdef COUNT_BCD_CHECK_EN
  input  logic                bcd,
  output logic                bcd_error,
`endif
  output logic [2*DATA_W-1:0] count_register,
  output logic                load,
  output logic                partial,
  output logic                programmed
);

  typedef enum logic [2:0] {
    UNPROG,
    LSB_ONLY,
    MSB_ONLY,
    WAIT_LSB,
    WAIT_MSB
  } state_t;

  state_t                r_state;
  logic [2*DATA_W-1:0]   r_cr;
  logic                  r_load;
  logic                  r_partial;
  logic                  r_programmed;

  logic                  w_ctrl_accept;
  logic                  w_write_accept;

  // A latch command (RW=00) is invisible here; any control word still drops a coincident byte.
  assign w_ctrl_accept  = ctrl_write && (rw_mode != 2'b00);
  assign w_write_accept = write && !ctrl_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= UNPROG;
      r_cr         <= '0;
      r_load       <= 1'b0;
      r_partial    <= 1'b0;
      r_programmed <= 1'b0;
    end else begin
      r_load <= 1'b0;
      if (w_ctrl_accept) begin
        r_programmed <= 1'b1;
        r_partial    <= 1'b0;
        unique case (rw_mode)
          2'b01:   r_state <= LSB_ONLY;
          2'b10:   r_state <= MSB_ONLY;
          default: r_state <= WAIT_LSB;
        endcase
      end else if (w_write_accept) begin
        case (r_state)
          LSB_ONLY: begin
            r_cr   <= {{DATA_W{1'b0}}, databus};
            r_load <= 1'b1;
          end
          MSB_ONLY: begin
            r_cr   <= {databus, {DATA_W{1'b0}}};
            r_load <= 1'b1;
          end
          WAIT_LSB: begin
            r_cr[DATA_W-1:0] <= databus;
            r_partial        <= 1'b1;
            r_state          <= WAIT_MSB;
          end
          WAIT_MSB: begin
            r_cr[2*DATA_W-1:DATA_W] <= databus;
            r_partial               <= 1'b0;
            r_load                  <= 1'b1;
            r_state                 <= WAIT_LSB;
          end
          default: ;
        endcase
      end
    end
  end

  assign count_register = r_cr;
  assign load           = r_load;
  assign partial        = r_partial;
  assign programmed     = r_programmed;

`ifdef COUNT_BCD_CHECK_EN
  logic r_bcd_mode;
  logic r_bcd_error;
  logic w_nibble_bad;
  logic w_byte_stored;

  always_comb begin
    w_nibble_bad = 1'b0;
    for (int unsigned i = 0; i < DATA_W / 4; i++) begin
      if (databus[4*i +: 4] > 4'd9) w_nibble_bad = 1'b1;
    end
  end

  assign w_byte_stored = w_write_accept && (r_state != UNPROG);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bcd_mode  <= 1'b0;
      r_bcd_error <= 1'b0;
    end else if (w_ctrl_accept) begin
      r_bcd_mode  <= bcd;
      r_bcd_error <= 1'b0;
    end else if (w_byte_stored && r_bcd_mode && w_nibble_bad) begin
      r_bcd_error <= 1'b1;
    end
  end

  assign bcd_error = r_bcd_error;
`endif

endmodule

// File: tb/tb_count_register_writer.sv
// Randomized self-checking bench for count_register_writer against a format-level reference model.
module tb_count_register_writer;

  logic        clk;
  logic        reset;
  logic [7:0]  databus;
  logic        write;
  logic        ctrl_write;
  logic [1:0]  rw_mode;
  logic [15:0] count_register;
  logic        load;
  logic        partial;
  logic        programmed;
`ifdef COUNT_BCD_CHECK_EN
  logic        bcd;
  logic        bcd_error;
`endif

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  // Reference model: format in force (0 none, 1 LSB, 2 MSB, 3 LSB then MSB) and whether a low byte is pending.
  int          m_format;
  bit          m_have_lsb;
  logic [15:0] exp_cr;
  bit          exp_load;
  bit          exp_prog;
  int unsigned n_loads;
`ifdef COUNT_BCD_CHECK_EN
  bit          m_bcd;
  bit          exp_bcd_err;
`endif

  count_register_writer #(.DATA_W(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .databus        (databus),
    .write          (write),
    .ctrl_write     (ctrl_write),
    .rw_mode        (rw_mode),
`ifdef COUNT_BCD_CHECK_EN
    .bcd            (bcd),
    .bcd_error      (bcd_error),
`endif
    .count_register (count_register),
    .load           (load),
    .partial        (partial),
    .programmed     (programmed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_format   = 0;
    m_have_lsb = 0;
    exp_cr     = 16'h0000;
    exp_load   = 0;
    exp_prog   = 0;
`ifdef COUNT_BCD_CHECK_EN
    m_bcd       = 0;
    exp_bcd_err = 0;
`endif
  endtask

`ifdef COUNT_BCD_CHECK_EN
  function automatic bit has_bad_digit(input logic [7:0] b);
    return (b[3:0] > 4'd9) || (b[7:4] > 4'd9);
  endfunction
`endif

  task automatic model_step(input bit w, input bit cw, input logic [1:0] rw, input logic [7:0] d);
    exp_load = 0;
    if (cw) begin
      if (rw != 2'b00) begin
        m_format   = int'(rw);
        m_have_lsb = 0;
        exp_prog   = 1;
`ifdef COUNT_BCD_CHECK_EN
        m_bcd       = bcd;
        exp_bcd_err = 0;
`endif
      end
    end else if (w && m_format != 0) begin
`ifdef COUNT_BCD_CHECK_EN
      if (m_bcd && has_bad_digit(d)) exp_bcd_err = 1;
`endif
      if (m_format == 1) begin
        exp_cr   = 16'(d);
        exp_load = 1;
      end else if (m_format == 2) begin
        exp_cr   = 16'(d) * 16'd256;
        exp_load = 1;
      end else if (!m_have_lsb) begin
        exp_cr     = (exp_cr & 16'hFF00) | 16'(d);
        m_have_lsb = 1;
      end else begin
        exp_cr     = (exp_cr & 16'h00FF) | (16'(d) * 16'd256);
        m_have_lsb = 0;
        exp_load   = 1;
      end
    end
  endtask

  task automatic check_outputs(input string where);
    check_eq({where, ".cr"},   32'(count_register), 32'(exp_cr));
    check_eq({where, ".load"}, 32'(load),           32'(exp_load));
    check_eq({where, ".part"}, 32'(partial),        32'(m_have_lsb));
    check_eq({where, ".prog"}, 32'(programmed),     32'(exp_prog));
`ifdef COUNT_BCD_CHECK_EN
    check_eq({where, ".bcde"}, 32'(bcd_error),      32'(exp_bcd_err));
`endif
  endtask

  // Drive one cycle's strobes from a falling edge, let the rising edge sample them, check at the next falling edge.
  task automatic cycle(input bit w, input bit cw, input logic [1:0] rw, input logic [7:0] d, input string where);
    write      = w;
    ctrl_write = cw;
    rw_mode    = rw;
    databus    = d;
    @(posedge clk);
    model_step(w, cw, rw, d);
    if (exp_load) n_loads++;
    @(negedge clk);
    check_outputs(where);
    write      = 0;
    ctrl_write = 0;
  endtask

  task automatic idle(input string where);
    cycle(0, 0, 2'b00, 8'h00, where);
  endtask

  // Reset is raised between edges so the outputs must clear without a clock.
  task automatic async_reset(input string where);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs(where);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; write = 0; ctrl_write = 0; rw_mode = 2'b00; databus = 8'h00;
`ifdef COUNT_BCD_CHECK_EN
    bcd = 0;
`endif
    n_loads = 0;
    model_reset();
    #12;
    check_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    // Unprogrammed: writes ignored
    cycle(1, 0, 2'b00, 8'h12, "unprog_wr");
    idle("unprog_idle");
    check_eq("unprog_no_load", n_loads, 0);

    // LSB only
    cycle(0, 1, 2'b01, 8'h00, "cw01");
    cycle(1, 0, 2'b00, 8'hA5, "lsb_a5");
    check_eq("lsb_a5_cr", 32'(count_register), 32'h00A5);
    check_eq("lsb_a5_load", 32'(load), 1);
    idle("lsb_after");
    check_eq("lsb_load_drop", 32'(load), 0);

    // MSB only
    cycle(0, 1, 2'b10, 8'h00, "cw10");
    cycle(1, 0, 2'b00, 8'h3C, "msb_3c");
    check_eq("msb_3c_cr", 32'(count_register), 32'h3C00);
    idle("msb_after");

    // LSB then MSB, then back-to-back pair
    cycle(0, 1, 2'b11, 8'h00, "cw11");
    cycle(1, 0, 2'b00, 8'h34, "pair_lo");
    check_eq("pair_lo_partial", 32'(partial), 1);
    cycle(1, 0, 2'b00, 8'h12, "pair_hi");
    check_eq("pair_1234", 32'(count_register), 32'h1234);
    cycle(1, 0, 2'b00, 8'h78, "b2b_lo");
    cycle(1, 0, 2'b00, 8'h56, "b2b_hi");
    check_eq("b2b_5678", 32'(count_register), 32'h5678);
    check_eq("b2b_load", 32'(load), 1);

    // Latch command mid-sequence does not disturb
    cycle(1, 0, 2'b00, 8'h34, "latch_lo");
    cycle(0, 1, 2'b00, 8'h00, "latch_cmd");
    check_eq("latch_partial", 32'(partial), 1);
    cycle(1, 0, 2'b00, 8'h12, "latch_hi");
    check_eq("latch_1234", 32'(count_register), 32'h1234);

    // New RW=11 control word mid-sequence aborts it
    cycle(1, 0, 2'b00, 8'hEF, "abort_lo");
    cycle(0, 1, 2'b11, 8'h00, "abort_cw");
    check_eq("abort_cr", 32'(count_register), 32'h12EF);
    cycle(1, 0, 2'b00, 8'hCD, "fresh_lo");
    cycle(1, 0, 2'b00, 8'hAB, "fresh_hi");
    check_eq("fresh_abcd", 32'(count_register), 32'hABCD);

    // Control word with a simultaneous write in WAIT_MSB drops the byte
    cycle(1, 0, 2'b00, 8'h11, "coll_lo");
    cycle(1, 1, 2'b11, 8'h99, "coll");
    check_eq("coll_cr", 32'(count_register), 32'hAB11);
    cycle(1, 0, 2'b00, 8'h00, "zero_lo");
    cycle(1, 0, 2'b00, 8'h00, "zero_hi");

    // Asynchronous reset mid-sequence
    cycle(1, 0, 2'b00, 8'h42, "pre_rst");
    async_reset("async_rst");

`ifdef COUNT_BCD_CHECK_EN
    bcd = 1;
    cycle(0, 1, 2'b01, 8'h00, "bcd_cw");
    cycle(1, 0, 2'b00, 8'h9A, "bcd_9a");
    check_eq("bcd_err_set", 32'(bcd_error), 1);
    cycle(0, 1, 2'b01, 8'h00, "bcd_clr");
    cycle(1, 0, 2'b00, 8'h99, "bcd_99");
    check_eq("bcd_err_99", 32'(bcd_error), 0);
    bcd = 0;
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
`ifdef COUNT_BCD_CHECK_EN
      bcd = 1'($urandom);
`endif
      if (r < 2) async_reset("rnd_rst");
      else cycle($urandom_range(0, 99) < 60, r < 14, 2'($urandom), 8'($urandom), "rnd");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/count_register_writer.md
Name: count_register_writer

Overview:
- Write-side counterpart of the counter's output latch: accepts CPU byte writes of the initial count from the data bus and assembles them into the 16-bit Count Register (CR).
- Follows the 8254 read/write format programmed by the last control word: LSB only, MSB only, or LSB then MSB.
- Signals the counting element when a complete new count is available.
- Sits between the bus interface / control word decoder and the counting element of one counter channel.

Parameters:
- DATA_W, 8, data bus width; CR width is 2*DATA_W.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high reset
- databus  input  DATA_W  byte written by CPU
- write  input  1  one-cycle strobe: databus holds a count byte for this counter
- ctrl_write  input  1  one-cycle strobe: control word addressed to this counter
- rw_mode  input  2  RW field of control word (00 latch cmd, 01 LSB, 10 MSB, 11 LSB then MSB); valid with ctrl_write
- count_register  output  2*DATA_W  assembled initial count (CR)
- load  output  1  one-cycle pulse: complete new count in count_register
- partial  output  1  high while LSB written and MSB awaited (RW=11)
- programmed  output  1  high once a non-latch control word has been accepted

Behaviour:
- Reset (async, any time): state UNPROG; count_register=0; load=0; partial=0; programmed=0.
- Any in-flight sequence is discarded on reset.
- States: UNPROG, LSB_ONLY, MSB_ONLY, WAIT_LSB, WAIT_MSB.
- ctrl_write with rw_mode:
  - 01 -> LSB_ONLY
  - 10 -> MSB_ONLY
  - 11 -> WAIT_LSB
  - programmed=1 for each of the above; partial=0; count_register unchanged; no load.
- ctrl_write with rw_mode=00 (latch command): ignored entirely. State, partial and count_register are unchanged, so a latch command between LSB and MSB does not break the sequence.
- write in UNPROG: ignored.
- write in LSB_ONLY: count_register={0, databus}; load=1 next cycle.
- write in MSB_ONLY: count_register={databus, 0}; load=1 next cycle.
- write in WAIT_LSB: count_register[DATA_W-1:0]=databus; upper byte unchanged; -> WAIT_MSB; partial=1; no load.
- write in WAIT_MSB: count_register[2*DATA_W-1:DATA_W]=databus; -> WAIT_LSB; partial=0; load=1 next cycle.
- Latency: strobe sampled at edge N; count_register, partial and load are registered and valid after edge N, for exactly one cycle in the case of load.
- Back-to-back writes every cycle are supported. Each completed count gives its own load pulse.
- Simultaneous ctrl_write and write: ctrl_write wins and the data byte is dropped. If this happens in WAIT_MSB, the half-written count is abandoned with no load.
- ctrl_write in WAIT_MSB (RW != 00): sequence aborted, partial=0. The low byte already written stays in count_register; no load.
- Count value 0 is passed through unchanged. Interpretation as the maximum count belongs to the counting element.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: COUNT_BCD_CHECK_EN
- Defined:
  - Adds input bcd (1 bit, sampled with ctrl_write, meaning BCD counting) and output bcd_error (1 bit).
  - With bcd=1, any written byte containing a nibble > 9 sets bcd_error on the same cycle the byte is stored.
  - bcd_error is sticky until the next ctrl_write with RW != 00, or reset.
  - The count is still stored and load still pulses.
- Not defined: bcd/bcd_error ports absent; no checking logic.

Test Plan:
- Reset, then write 8'h12 with no control word -> count_register=16'h0000, load never pulses, programmed=0.
- ctrl_write rw=01, write 8'hA5 -> next cycle count_register=16'h00A5 and load=1 for one cycle. Repeat with rw=10, 8'h3C -> 16'h3C00, one load.
- ctrl_write rw=11, write 8'h34 -> partial=1, no load. Then write 8'h12 -> count_register=16'h1234, load one cycle, partial=0. Then 8'h78 and 8'h56 on consecutive cycles -> 16'h5678 with a second load.
- rw=11, write 8'h34, ctrl_write rw=00 (latch), write 8'h12 -> 16'h1234 with load (latch does not disturb). Repeat with ctrl_write rw=11 instead of the latch -> partial=0, no load, next two writes assemble a fresh count.
- ctrl_write and write asserted in the same cycle in WAIT_MSB -> byte dropped, no load, state WAIT_LSB. Assert reset mid-sequence (partial=1) -> all outputs 0 immediately, before the next clock edge.
- With COUNT_BCD_CHECK_EN: bcd=1, rw=01, write 8'h9A -> bcd_error=1, count 16'h009A loaded. Next ctrl_write clears it. Write 8'h99 -> bcd_error stays 0.
